// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with hold/backpressure, branch redirect, timeout and misalignment halt
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [63:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        branch_taken,
  input  logic [63:0] branch_imm,
  output logic        fetch_err
);
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_e;
  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d, pc_out_q, pc_out_d, next_pc;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d, last_wait;
  // cnt_q holds completed un-acked request cycles, so the current cycle number is cnt_q+1
  assign last_wait = (cnt_q + 8'd1) == 8'(TIMEOUT);
  assign next_pc   = pc_out_q + (branch_taken ? branch_imm : 64'd4);
  // next-state: fetch until ack or timeout, hold until transfer, halt on any error
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          inst_d   = imem_rdata;
          pc_out_d = pc_q;
          cnt_d    = '0;
          state_d  = HOLD;
        end else if (last_wait) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          if (|next_pc[1:0]) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase
  end
  // state registers, cleared asynchronously so nothing of an in-flight fetch survives reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
  // the request is gated by rst_n because reset parks the FSM in FETCH
  assign imem_req   = rst_n && (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = state_q == HOLD;
  assign inst_out   = inst_q;
  assign pc_out     = pc_out_q;
  assign fetch_err  = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: transaction-level model of fetch/hold/redirect/timeout driven with random latency and backpressure
module tb_instr_fetch_unit;
  localparam int          TO  = 4;
  localparam logic [63:0] RPC = 64'h0;
  logic        clk = 0, rst_n = 0, imem_ack = 0, inst_ready = 0, branch_taken = 0;
  logic        imem_req, inst_valid, fetch_err;
  logic [63:0] imem_addr, pc_out, branch_imm = '0;
  logic [31:0] imem_rdata = '0, inst_out;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] m_pc;
  bit          halted;

  instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
    .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .branch_imm(branch_imm), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst_n = 0;
    imem_ack = 0; inst_ready = 0; branch_taken = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_err", fetch_err, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, RPC);
    m_pc = RPC;
    halted = 0;
  endtask

  task automatic halt_check(input int n);
    for (int k = 0; k < n; k++) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      tick;
      chk("halt_req", imem_req, 0);
      chk("halt_valid", inst_valid, 0);
      chk("halt_err", fetch_err, 1);
    end
    imem_ack = 0;
  endtask

  // one fetch transaction: ack in request cycle lat, hold for the given cycles, then transfer
  task automatic fetch_one(input int lat, input int hold, input bit br, input logic [63:0] imm, input bit rst_in_hold);
    logic [31:0] d;
    bit acked;
    d = $urandom;
    acked = 0;
    for (int c = 1; c <= TO + 3 && !acked && !halted; c++) begin
      chk("req", imem_req, 1);
      chk("addr", imem_addr, m_pc);
      chk("valid_fetch", inst_valid, 0);
      imem_ack = (c == lat);
      imem_rdata = (c == lat) ? d : $urandom;
      tick;
      imem_ack = 0;
      if (c == lat) acked = 1;
      else if (c == TO) begin
        halted = 1;
        chk("timeout_err", fetch_err, 1);
        chk("timeout_req", imem_req, 0);
        chk("timeout_valid", inst_valid, 0);
      end
    end
    if (halted) return;
    chk("hold_valid", inst_valid, 1);
    chk("hold_inst", inst_out, d);
    chk("hold_pc", pc_out, m_pc);
    chk("hold_err", fetch_err, 0);
    chk("hold_req", imem_req, 0);
    for (int k = 0; k < hold; k++) begin
      inst_ready = 0;
      branch_taken = 1'($urandom);
      branch_imm = {$urandom, $urandom};
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      tick;
      chk("bp_valid", inst_valid, 1);
      chk("bp_inst", inst_out, d);
      chk("bp_pc", pc_out, m_pc);
      chk("bp_req", imem_req, 0);
      if (rst_in_hold) begin
        do_reset;
        return;
      end
    end
    inst_ready = 1;
    imem_ack = 1'($urandom);
    branch_taken = br;
    branch_imm = imm;
    tick;
    inst_ready = 0;
    imem_ack = 0;
    branch_taken = 1'($urandom);
    branch_imm = {$urandom, $urandom};
    m_pc = br ? m_pc + imm : m_pc + 64'd4;
    chk("xfer_valid", inst_valid, 0);
    if (m_pc[1:0] != 2'b00) begin
      halted = 1;
      chk("misalign_err", fetch_err, 1);
      chk("misalign_req", imem_req, 0);
    end else begin
      chk("xfer_err", fetch_err, 0);
    end
  endtask

  initial begin
    halted = 0;
    m_pc = RPC;
    do_reset;
    for (int i = 0; i < 4; i++) fetch_one(3, 0, 0, 0, 0);
    fetch_one(2, 0, 1, -64'sd8, 0);
    chk("branch_neg_addr", imem_addr, 64'h8);
    fetch_one(1, 0, 0, 0, 0);
    fetch_one(2, 0, 0, 0, 0);
    fetch_one(2, 0, 1, 64'h100, 0);
    chk("branch_pos_addr", imem_addr, 64'h110);
    fetch_one(2, 5, 0, 0, 0);
    fetch_one(7, 0, 0, 0, 0);
    chk("timeout_halted", 64'(halted), 1);
    halt_check(4);
    do_reset;
    fetch_one(4, 1, 0, 0, 0);
    chk("boundary_err", fetch_err, 0);
    fetch_one(2, 0, 1, 64'h2, 0);
    halt_check(3);
    do_reset;
    fetch_one(2, 3, 0, 0, 1);
    fetch_one(1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int lat;
      logic [63:0] imm;
      lat = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
      imm = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) imm[1:0] = 2'b00;
      fetch_one(lat, $urandom_range(0, 3), 1'($urandom), imm, $urandom_range(0, 19) == 0);
      if (halted) begin
        halt_check(2);
        do_reset;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for imem_ack; legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, 64 bits: fetch byte address.
REQ-007 SHALL have port imem_ack, input, 1 bit: memory response valid.
REQ-008 SHALL have port imem_rdata, input, 32 bits: instruction word; valid only when imem_ack=1.
REQ-009 SHALL have port inst_out, output, 32 bits: instruction to the decode/immediate-generation stage.
REQ-010 SHALL have port pc_out, output, 64 bits: PC of inst_out.
REQ-011 SHALL have port inst_valid, output, 1 bit: inst_out/pc_out hold a valid instruction.
REQ-012 SHALL have port inst_ready, input, 1 bit: the downstream stage accepts the instruction.
REQ-013 SHALL have port branch_taken, input, 1 bit: the consumed instruction redirects the PC.
REQ-014 SHALL have port branch_imm, input, 64 bits: sign-extended byte offset from immediate generation.
REQ-015 SHALL have port fetch_err, output, 1 bit: sticky error flag (timeout or misaligned target).

Function
REQ-016 SHALL implement a three-state FSM with states FETCH, HOLD and HALT.
REQ-017 SHALL drive imem_req=1 only in FETCH, with imem_addr equal to the internal PC held constant until ack.
REQ-018 SHALL, in FETCH, on imem_ack=1 capture imem_rdata into inst_out and PC into pc_out, and enter HOLD the next cycle.
REQ-019 SHALL give a latency of exactly one cycle from ack: inst_valid rises in the cycle after imem_ack.
REQ-020 SHALL keep inst_valid=1 and inst_out/pc_out stable in HOLD until the transfer cycle (inst_valid=1 and inst_ready=1).
REQ-021 SHALL, in the transfer cycle, compute next PC = pc_out + branch_imm (modulo 2^64) if branch_taken=1, else pc_out + 4.
REQ-022 SHALL, in the transfer cycle, enter FETCH at the next PC with inst_valid=0 the following cycle.
REQ-023 SHALL sample branch_taken and branch_imm only in the transfer cycle; their values at other times have no effect.
REQ-024 SHALL treat a next PC with bits[1:0]!=0 as misaligned: set fetch_err, enter HALT, and issue no request.
REQ-025 SHALL count FETCH cycles without ack, starting at 1 in the first request cycle.
REQ-026 SHALL, if the count reaches TIMEOUT without ack, set fetch_err and enter HALT on that edge.
REQ-027 SHALL accept an ack that arrives in the TIMEOUT-th cycle as a normal ack: no error.
REQ-028 SHALL, in HALT, hold imem_req=0 and inst_valid=0, and ignore imem_ack; HALT is left only by reset.
REQ-029 SHALL ignore imem_ack in HOLD.
REQ-030 SHALL keep fetch_err sticky until reset.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force: state=FETCH, PC=RESET_PC, imem_req=0, inst_valid=0, inst_out=32'h0, pc_out=64'h0, fetch_err=0, timeout counter=0.
REQ-032 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n deasserts.
REQ-033 SHALL, on reset during a pending fetch or HOLD, discard the in-flight or held instruction, with no partial state surviving.

Verification
REQ-034 Sequential fetch: ack 2 cycles after every request, inst_ready=1, branch_taken=0 -> pc_out sequence 0,4,8,12; inst_out matches imem_rdata.
REQ-035 Branch: instruction at PC 0x10 transferred with branch_taken=1, branch_imm=-8 -> next imem_addr=0x08; with branch_imm=0x100 -> next imem_addr=0x110.
REQ-036 Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_out, pc_out and inst_valid stable, imem_req=0; transfer on the 6th cycle.
REQ-037 Timeout, TIMEOUT=4: no ack -> fetch_err=1 after the 4th request cycle; HALT is held and a later ack is ignored.
REQ-038 Timeout boundary, TIMEOUT=4: ack in the 4th cycle -> fetch_err=0 and normal HOLD.
REQ-039 Misaligned target: branch_imm=2 -> fetch_err=1 and imem_req=0; reset mid-HOLD -> all outputs return to reset values, then a request at RESET_PC.
